// File: rtl/issue_scheduler.sv
// issue_scheduler: dual-issue scheduler between decode and the two execute lanes.
// Slot A (older) always goes to lane 0. Slot B (younger) goes to lane 1 when the
// pair is hazard-free. Otherwise B is parked in a one-entry hold register and
// issues alone in lane 0 on the following cycle. Load-use hazards against the
// previous cycle's load insert bubbles.
// Optional feature: define ISSUE_SCHED_PERF_EN to build the dual-issue and
// bubble performance counters; without it both counter outputs read 16'h0000.
module issue_scheduler #(
   parameter int CTRL_W = 6
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_flush,
   input  logic              i_stall,
   input  logic              i_valid_a,
   input  logic              i_valid_b,
   input  logic [CTRL_W-1:0] i_ctrl_a,
   input  logic [CTRL_W-1:0] i_ctrl_b,
   input  logic [3:0]        i_rd_a,
   input  logic [3:0]        i_rn_a,
   input  logic [3:0]        i_rm_a,
   input  logic [3:0]        i_rd_b,
   input  logic [3:0]        i_rn_b,
   input  logic [3:0]        i_rm_b,
   input  logic [1:0]        i_use_a,
   input  logic [1:0]        i_use_b,
   output logic              o_ready,
   output logic              o_lane0_valid,
   output logic              o_lane0_from_hold,
   output logic              o_lane1_valid,
   output logic [15:0]       o_dual_cnt,
   output logic [15:0]       o_bubble_cnt
);

   // Control bundle bit positions, MSB first: RegWrite, MemtoReg, MemWrite,
   // Branch, FlagWrite, CondUse.
   localparam int RW  = CTRL_W - 1;
   localparam int MTR = CTRL_W - 2;
   localparam int MW  = CTRL_W - 3;
   localparam int BR  = CTRL_W - 4;
   localparam int FW  = CTRL_W - 5;
   localparam int CU  = CTRL_W - 6;

   typedef enum logic {ST_NORMAL, ST_HOLD} state_t;

   // True when an instruction's used source (Rn and/or Rm) matches register r.
   function automatic logic src_hit(input logic [1:0] use_f, input logic [3:0] rn,
                                    input logic [3:0] rm, input logic [3:0] r);
      return (use_f[1] && (rn == r)) || (use_f[0] && (rm == r));
   endfunction

   state_t      state_q, state_d;
   // Hold register: only the fields the lone lane-0 issue still needs.
   logic [3:0]  hold_rd_q, hold_rd_d;
   logic [3:0]  hold_rn_q, hold_rn_d;
   logic [3:0]  hold_rm_q, hold_rm_d;
   logic [1:0]  hold_use_q, hold_use_d;
   logic        hold_load_q, hold_load_d;
   // Destination of the load issued last cycle.
   logic        ll_v_q, ll_v_d;
   logic [3:0]  ll_rd_q, ll_rd_d;

   logic ready_c, lane0_c, from_hold_c, lane1_c;
   logic dual_ev, bubble_ev;

   logic load_a, load_b, mem_a, mem_b;
   logic lu_a, lu_b, lu_hold, b_legal;
   logic unused_ctrl;

   assign load_a  = i_ctrl_a[RW] & i_ctrl_a[MTR];
   assign load_b  = i_ctrl_b[RW] & i_ctrl_b[MTR];
   assign mem_a   = i_ctrl_a[MTR] | i_ctrl_a[MW];
   assign mem_b   = i_ctrl_b[MTR] | i_ctrl_b[MW];
   assign lu_a    = ll_v_q & src_hit(i_use_a, i_rn_a, i_rm_a, ll_rd_q);
   assign lu_b    = ll_v_q & src_hit(i_use_b, i_rn_b, i_rm_b, ll_rd_q);
   assign lu_hold = ll_v_q & src_hit(hold_use_q, hold_rn_q, hold_rm_q, ll_rd_q);

   // Pair legality: any intra-pair hazard, a control-flow instruction in either
   // slot (branches live in lane 0 only, and Rd=15 writes are branches too), or
   // a load-use hit on B forces a split.
   assign b_legal = ~((i_ctrl_a[RW] & src_hit(i_use_b, i_rn_b, i_rm_b, i_rd_a))
                    | (i_ctrl_a[RW] & i_ctrl_b[RW] & (i_rd_a == i_rd_b))
                    | (mem_a & mem_b)
                    | i_ctrl_a[BR] | (i_ctrl_a[RW] & (i_rd_a == 4'd15))
                    | i_ctrl_b[BR] | (i_ctrl_b[RW] & (i_rd_b == 4'd15))
                    | (i_ctrl_a[FW] & i_ctrl_b[CU])
                    | lu_b);

   // A's CondUse and B's FlagWrite never matter inside a pair.
   assign unused_ctrl = i_ctrl_a[CU] ^ i_ctrl_b[FW];

   // Issue decision and next-state computation.
   always_comb begin
      state_d     = state_q;
      hold_rd_d   = hold_rd_q;
      hold_rn_d   = hold_rn_q;
      hold_rm_d   = hold_rm_q;
      hold_use_d  = hold_use_q;
      hold_load_d = hold_load_q;
      ll_v_d      = ll_v_q;
      ll_rd_d     = ll_rd_q;
      ready_c     = 1'b0;
      lane0_c     = 1'b0;
      from_hold_c = 1'b0;
      lane1_c     = 1'b0;
      dual_ev     = 1'b0;
      bubble_ev   = 1'b0;
      if (i_flush) begin
         // Redirect: discard the presented pair and anything held.
         ready_c     = 1'b1;
         state_d     = ST_NORMAL;
         hold_rd_d   = '0;
         hold_rn_d   = '0;
         hold_rm_d   = '0;
         hold_use_d  = '0;
         hold_load_d = 1'b0;
         ll_v_d      = 1'b0;
      end else if (!i_stall) begin
         // Load tracker only survives if a load issues this cycle.
         ll_v_d = 1'b0;
         if (state_q == ST_HOLD) begin
            if (lu_hold) begin
               bubble_ev = 1'b1;
            end else begin
               lane0_c     = 1'b1;
               from_hold_c = 1'b1;
               state_d     = ST_NORMAL;
               if (hold_load_q) begin
                  ll_v_d  = 1'b1;
                  ll_rd_d = hold_rd_q;
               end
            end
         end else if (!i_valid_a) begin
            // Empty (or B-only) pair is simply consumed.
            ready_c = 1'b1;
         end else if (lu_a) begin
            bubble_ev = 1'b1;
         end else begin
            lane0_c = 1'b1;
            ready_c = 1'b1;
            if (load_a) begin
               ll_v_d  = 1'b1;
               ll_rd_d = i_rd_a;
            end
            if (i_valid_b) begin
               if (b_legal) begin
                  lane1_c = 1'b1;
                  dual_ev = 1'b1;
                  if (load_b) begin
                     ll_v_d  = 1'b1;
                     ll_rd_d = i_rd_b;
                  end
               end else begin
                  state_d     = ST_HOLD;
                  hold_rd_d   = i_rd_b;
                  hold_rn_d   = i_rn_b;
                  hold_rm_d   = i_rm_b;
                  hold_use_d  = i_use_b;
                  hold_load_d = load_b;
               end
            end
         end
      end
   end

   // Scheduler state, hold register and load tracker.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q     <= ST_NORMAL;
         hold_rd_q   <= '0;
         hold_rn_q   <= '0;
         hold_rm_q   <= '0;
         hold_use_q  <= '0;
         hold_load_q <= 1'b0;
         ll_v_q      <= 1'b0;
         ll_rd_q     <= '0;
      end else begin
         state_q     <= state_d;
         hold_rd_q   <= hold_rd_d;
         hold_rn_q   <= hold_rn_d;
         hold_rm_q   <= hold_rm_d;
         hold_use_q  <= hold_use_d;
         hold_load_q <= hold_load_d;
         ll_v_q      <= ll_v_d;
         ll_rd_q     <= ll_rd_d;
      end
   end

   // Issue outputs are combinational, so they are masked while reset is held.
   assign o_ready           = i_rst_n & ready_c;
   assign o_lane0_valid     = i_rst_n & lane0_c;
   assign o_lane0_from_hold = i_rst_n & from_hold_c;
   assign o_lane1_valid     = i_rst_n & lane1_c;

`ifdef ISSUE_SCHED_PERF_EN
   logic [15:0] dual_cnt_q, bubble_cnt_q;

   // Saturating performance counters; events are already suppressed on
   // stall and flush cycles.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         dual_cnt_q   <= '0;
         bubble_cnt_q <= '0;
      end else begin
         if (dual_ev && (dual_cnt_q != 16'hFFFF))
            dual_cnt_q <= dual_cnt_q + 16'd1;
         if (bubble_ev && (bubble_cnt_q != 16'hFFFF))
            bubble_cnt_q <= bubble_cnt_q + 16'd1;
      end
   end

   assign o_dual_cnt   = dual_cnt_q;
   assign o_bubble_cnt = bubble_cnt_q;
`else
   logic unused_perf;
   assign unused_perf  = dual_ev ^ bubble_ev;
   assign o_dual_cnt   = 16'h0000;
   assign o_bubble_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_issue_scheduler.sv
// tb_issue_scheduler: directed test of issue_scheduler against an
// instruction-level model (held-instruction queue, last-load register,
// issue counters) that is compared with the DUT on every falling edge.
module tb_issue_scheduler;

`ifdef ISSUE_SCHED_PERF_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   // Control encodings {RegWrite, MemtoReg, MemWrite, Branch, FlagWrite, CondUse}
   localparam logic [5:0] C_ALU   = 6'b100000;
   localparam logic [5:0] C_ALUCC = 6'b100001;
   localparam logic [5:0] C_LDR   = 6'b110000;
   localparam logic [5:0] C_STR   = 6'b001000;
   localparam logic [5:0] C_B     = 6'b000100;
   localparam logic [5:0] C_BL    = 6'b100100;
   localparam logic [5:0] C_CMP   = 6'b000010;

   typedef struct packed {
      logic       v;
      logic [5:0] c;
      logic [3:0] rd;
      logic [3:0] rn;
      logic [3:0] rm;
      logic [1:0] u;
   } ins_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic flush = 1'b0;
   logic stall = 1'b0;
   ins_t cur_a = '0;
   ins_t cur_b = '0;

   logic        o_ready, o_l0, o_fh, o_l1;
   logic [15:0] o_dual, o_bub;

   int n_chk = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   issue_scheduler #(.CTRL_W(6)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush), .i_stall(stall),
      .i_valid_a(cur_a.v), .i_valid_b(cur_b.v),
      .i_ctrl_a(cur_a.c), .i_ctrl_b(cur_b.c),
      .i_rd_a(cur_a.rd), .i_rn_a(cur_a.rn), .i_rm_a(cur_a.rm),
      .i_rd_b(cur_b.rd), .i_rn_b(cur_b.rn), .i_rm_b(cur_b.rm),
      .i_use_a(cur_a.u), .i_use_b(cur_b.u),
      .o_ready(o_ready), .o_lane0_valid(o_l0), .o_lane0_from_hold(o_fh),
      .o_lane1_valid(o_l1), .o_dual_cnt(o_dual), .o_bubble_cnt(o_bub)
   );

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic ins_t mk(input logic [5:0] c, input logic [3:0] rd,
                               input logic [3:0] rn, input logic [3:0] rm,
                               input logic [1:0] u);
      ins_t r;
      r.v = 1'b1; r.c = c; r.rd = rd; r.rn = rn; r.rm = rm; r.u = u;
      return r;
   endfunction

   // ---------------- instruction-level model ----------------
   ins_t held[$];
   ins_t p_held[$];
   int   last_ld = -1, p_ld = -1;
   int   m_dual = 0, p_dual = 0;
   int   m_bub = 0, p_bub = 0;

   function automatic bit reads(input ins_t x, input int r);
      if (r < 0) return 1'b0;
      return (x.u[1] && int'(x.rn) == r) || (x.u[0] && int'(x.rm) == r);
   endfunction

   function automatic bit ctl_flow(input ins_t x);
      return x.c[2] || (x.c[5] && x.rd == 4'd15);
   endfunction

   function automatic bit mem_op(input ins_t x);
      return x.c[4] || x.c[3];
   endfunction

   function automatic bit pair_ok(input ins_t a, input ins_t b, input int ld);
      if (a.c[5] && reads(b, int'(a.rd))) return 1'b0;
      if (a.c[5] && b.c[5] && a.rd == b.rd) return 1'b0;
      if (mem_op(a) && mem_op(b)) return 1'b0;
      if (ctl_flow(a) || ctl_flow(b)) return 1'b0;
      if (a.c[1] && b.c[0]) return 1'b0;
      if (reads(b, ld)) return 1'b0;
      return 1'b1;
   endfunction

   // Per-cycle comparison and next-state computation.
   always @(negedge clk) begin
      bit   e_l0, e_fh, e_l1, e_rdy, bub;
      ins_t iss[$];
      e_l0 = 0; e_fh = 0; e_l1 = 0; e_rdy = 0; bub = 0;
      iss.delete();
      p_held = held; p_ld = last_ld; p_dual = m_dual; p_bub = m_bub;
      if (!rst_n) begin
         p_held.delete(); p_ld = -1; p_dual = 0; p_bub = 0;
      end else if (flush) begin
         e_rdy = 1; p_held.delete(); p_ld = -1;
      end else if (!stall) begin
         if (held.size() != 0) begin
            if (reads(held[0], last_ld)) bub = 1;
            else begin
               e_l0 = 1; e_fh = 1; iss.push_back(held[0]); p_held.delete();
            end
         end else if (!cur_a.v) begin
            e_rdy = 1;
         end else if (reads(cur_a, last_ld)) begin
            bub = 1;
         end else begin
            e_l0 = 1; e_rdy = 1; iss.push_back(cur_a);
            if (cur_b.v) begin
               if (pair_ok(cur_a, cur_b, last_ld)) begin
                  e_l1 = 1; iss.push_back(cur_b);
               end else p_held.push_back(cur_b);
            end
         end
         p_ld = -1;
         foreach (iss[i]) if (iss[i].c[5] && iss[i].c[4]) p_ld = int'(iss[i].rd);
         if (bub && p_bub < 65535) p_bub++;
         if (iss.size() == 2 && p_dual < 65535) p_dual++;
      end
      chk("m_lane0", {15'd0, o_l0}, {15'd0, e_l0});
      chk("m_from_hold", {15'd0, o_fh}, {15'd0, e_fh});
      chk("m_lane1", {15'd0, o_l1}, {15'd0, e_l1});
      chk("m_ready", {15'd0, o_ready}, {15'd0, e_rdy});
      chk("m_dual_cnt", o_dual, PERF ? 16'(m_dual) : 16'h0);
      chk("m_bubble_cnt", o_bub, PERF ? 16'(m_bub) : 16'h0);
   end

   always @(posedge clk) begin
      if (rst_n) begin
         held = p_held; last_ld = p_ld; m_dual = p_dual; m_bub = p_bub;
      end
   end

   always @(negedge rst_n) begin
      held.delete(); last_ld = -1; m_dual = 0; m_bub = 0;
   end

   // ---------------- directed stimulus ----------------
   task automatic setp(input ins_t a, input ins_t b, input logic fl, input logic st);
      cur_a = a; cur_b = b; flush = fl; stall = st;
   endtask

   task automatic nxt;
      @(posedge clk); #1;
   endtask

   task automatic expo(input string nm, input logic l0, input logic fh,
                       input logic l1, input logic rdy);
      chk({nm, " lane0"}, {15'd0, o_l0}, {15'd0, l0});
      chk({nm, " from_hold"}, {15'd0, o_fh}, {15'd0, fh});
      chk({nm, " lane1"}, {15'd0, o_l1}, {15'd0, l1});
      chk({nm, " ready"}, {15'd0, o_ready}, {15'd0, rdy});
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      ins_t nop, add123, sub45, sub41;
      nop    = '0;
      add123 = mk(C_ALU, 4'd1, 4'd2, 4'd3, 2'b11);
      sub45  = mk(C_ALU, 4'd4, 4'd5, 4'd0, 2'b10);
      sub41  = mk(C_ALU, 4'd4, 4'd1, 4'd0, 2'b10);

      // Reset state with a valid pair presented.
      setp(add123, sub45, 1'b0, 1'b0);
      repeat (2) @(posedge clk);
      #2 expo("reset", 0, 0, 0, 0);
      chk("reset dual_cnt", o_dual, 16'h0);
      chk("reset bubble_cnt", o_bub, 16'h0);
      rst_n = 1'b1;
      setp(nop, nop, 1'b0, 1'b0);
      nxt;

      // Independent pair dual-issues.
      setp(add123, sub45, 1'b0, 1'b0); #1 expo("dual", 1, 0, 1, 1); nxt;
      setp(nop, nop, 1'b0, 1'b0); #1 expo("idle", 0, 0, 0, 1);
      chk("dual_cnt after dual", o_dual, PERF ? 16'd1 : 16'd0); nxt;

      // RAW split: A, then B from hold, then NORMAL again.
      setp(add123, sub41, 1'b0, 1'b0); #1 expo("raw c0", 1, 0, 0, 1); nxt;
      setp(nop, nop, 1'b0, 1'b0); #1 expo("raw c1", 1, 1, 0, 0); nxt;
      #1 expo("raw c2", 0, 0, 0, 1); nxt;

      // Single memory port: LDR + STR splits.
      setp(mk(C_LDR, 4'd2, 4'd0, 4'd0, 2'b10), mk(C_STR, 4'd0, 4'd0, 4'd3, 2'b11), 1'b0, 1'b0);
      #1 expo("mem c0", 1, 0, 0, 1); nxt;
      setp(nop, nop, 1'b0, 1'b0); #1 expo("mem c1", 1, 1, 0, 0); nxt;

      // Branch in A, then BL in B.
      setp(mk(C_B, 4'd0, 4'd0, 4'd0, 2'b00), add123, 1'b0, 1'b0); #1 expo("br_a c0", 1, 0, 0, 1); nxt;
      setp(nop, nop, 1'b0, 1'b0); #1 expo("br_a c1", 1, 1, 0, 0); nxt;
      setp(add123, mk(C_BL, 4'd14, 4'd0, 4'd0, 2'b00), 1'b0, 1'b0); #1 expo("bl c0", 1, 0, 0, 1); nxt;
      setp(nop, nop, 1'b0, 1'b0); #1 expo("bl c1", 1, 1, 0, 0); nxt;

      // Load-use bubble.
      setp(mk(C_LDR, 4'd5, 4'd0, 4'd0, 2'b10), nop, 1'b0, 1'b0); #1 expo("lu c0", 1, 0, 0, 1); nxt;
      setp(mk(C_ALU, 4'd6, 4'd5, 4'd1, 2'b11), nop, 1'b0, 1'b0); #1 expo("lu c1", 0, 0, 0, 0); nxt;
      #1 expo("lu c2", 1, 0, 0, 1);
      chk("bubble_cnt after lu", o_bub, PERF ? 16'd1 : 16'd0); nxt;

      // Flags: CMP + conditional splits, CMP + unconditional dual-issues.
      setp(mk(C_CMP, 4'd0, 4'd1, 4'd2, 2'b11), mk(C_ALUCC, 4'd3, 4'd4, 4'd5, 2'b11), 1'b0, 1'b0);
      #1 expo("flag cc c0", 1, 0, 0, 1); nxt;
      setp(nop, nop, 1'b0, 1'b0); #1 expo("flag cc c1", 1, 1, 0, 0); nxt;
      setp(mk(C_CMP, 4'd0, 4'd1, 4'd2, 2'b11), mk(C_ALU, 4'd3, 4'd4, 4'd5, 2'b11), 1'b0, 1'b0);
      #1 expo("flag nocc", 1, 0, 1, 1); nxt;
      setp(nop, nop, 1'b0, 1'b0); #1 chk("dual_cnt after flags", o_dual, PERF ? 16'd2 : 16'd0); nxt;

      // Stall for 3 cycles in HOLD.
      setp(add123, sub41, 1'b0, 1'b0); #1 expo("stall c0", 1, 0, 0, 1); nxt;
      for (int i = 0; i < 3; i++) begin
         setp(nop, nop, 1'b0, 1'b1); #1 expo("stall hold", 0, 0, 0, 0);
         chk("stall dual_cnt", o_dual, PERF ? 16'd2 : 16'd0);
         chk("stall bubble_cnt", o_bub, PERF ? 16'd1 : 16'd0); nxt;
      end
      setp(nop, nop, 1'b0, 1'b0); #1 expo("stall release", 1, 1, 0, 0); nxt;

      // Flush in HOLD, and flush overriding stall in NORMAL.
      setp(add123, sub41, 1'b0, 1'b0); #1 expo("flush c0", 1, 0, 0, 1); nxt;
      setp(nop, nop, 1'b1, 1'b0); #1 expo("flush c1", 0, 0, 0, 1); nxt;
      setp(nop, nop, 1'b0, 1'b0); #1 expo("flush c2", 0, 0, 0, 1); nxt;
      setp(add123, sub45, 1'b1, 1'b1); #1 expo("flush+stall", 0, 0, 0, 1); nxt;

      // B without A is dropped.
      setp(nop, add123, 1'b0, 1'b0); #1 expo("b only", 0, 0, 0, 1); nxt;

      // Same Rd, and an A that writes the PC.
      setp(add123, mk(C_ALU, 4'd1, 4'd0, 4'd0, 2'b00), 1'b0, 1'b0); #1 expo("waw c0", 1, 0, 0, 1); nxt;
      setp(nop, nop, 1'b0, 1'b0); #1 expo("waw c1", 1, 1, 0, 0); nxt;
      setp(mk(C_ALU, 4'd15, 4'd2, 4'd3, 2'b11), sub45, 1'b0, 1'b0); #1 expo("pc c0", 1, 0, 0, 1); nxt;
      setp(nop, nop, 1'b0, 1'b0); #1 expo("pc c1", 1, 1, 0, 0); nxt;

      // Load in lane 1 feeds a load-use bubble.
      setp(add123, mk(C_LDR, 4'd9, 4'd0, 4'd0, 2'b10), 1'b0, 1'b0); #1 expo("ldb c0", 1, 0, 1, 1); nxt;
      setp(mk(C_ALU, 4'd6, 4'd9, 4'd1, 2'b11), nop, 1'b0, 1'b0); #1 expo("ldb c1", 0, 0, 0, 0); nxt;
      #1 expo("ldb c2", 1, 0, 0, 1); nxt;

      // Load-use on B alone forces a split.
      setp(mk(C_LDR, 4'd7, 4'd0, 4'd0, 2'b10), nop, 1'b0, 1'b0); #1 expo("lub c0", 1, 0, 0, 1); nxt;
      setp(add123, mk(C_ALU, 4'd4, 4'd7, 4'd2, 2'b11), 1'b0, 1'b0); #1 expo("lub c1", 1, 0, 0, 1); nxt;
      setp(nop, nop, 1'b0, 1'b0); #1 expo("lub c2", 1, 1, 0, 0); nxt;

      // Held instruction load-use blocked: bubble while staying in HOLD.
      setp(mk(C_LDR, 4'd7, 4'd0, 4'd0, 2'b10), mk(C_ALU, 4'd8, 4'd7, 4'd1, 2'b11), 1'b0, 1'b0);
      #1 expo("luh c0", 1, 0, 0, 1); nxt;
      setp(nop, nop, 1'b0, 1'b0); #1 expo("luh c1", 0, 0, 0, 0); nxt;
      #1 expo("luh c2", 1, 1, 0, 0); nxt;
      #1 expo("luh c3", 0, 0, 0, 1); nxt;

`ifdef ISSUE_SCHED_PERF_EN
      // Counter saturation.
      setp(add123, sub45, 1'b0, 1'b0);
      repeat (65540) nxt;
      #1 chk("dual_cnt saturated", o_dual, 16'hFFFF);
      setp(nop, nop, 1'b0, 1'b0); nxt;
`endif

      // Asynchronous reset pulse mid-HOLD.
      setp(add123, sub41, 1'b0, 1'b0); #1 expo("rst c0", 1, 0, 0, 1); nxt;
      setp(nop, nop, 1'b0, 1'b0); #1 expo("rst c1 pre", 1, 1, 0, 0);
      #1 rst_n = 1'b0;
      #1 expo("rst pulse", 0, 0, 0, 0);
      chk("rst pulse dual_cnt", o_dual, 16'h0);
      chk("rst pulse bubble_cnt", o_bub, 16'h0);
      #3 rst_n = 1'b1;
      setp(add123, sub45, 1'b0, 1'b0);
      nxt;
      #1 expo("after rst", 1, 0, 1, 1); nxt;
      setp(nop, nop, 1'b0, 1'b0); nxt;
      nxt;

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
